// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, ALUOp encodings and the issue payload.
package alu_pkg;

    localparam int ALU_DATA_WIDTH = 32;
    localparam int ALU_OP_WIDTH   = 4;

    localparam logic [ALU_OP_WIDTH-1:0] OP_AND = 4'b0000;
    localparam logic [ALU_OP_WIDTH-1:0] OP_OR  = 4'b0001;
    localparam logic [ALU_OP_WIDTH-1:0] OP_ADD = 4'b0010;
    localparam logic [ALU_OP_WIDTH-1:0] OP_XOR = 4'b0011;
    localparam logic [ALU_OP_WIDTH-1:0] OP_SUB = 4'b0100;
    localparam logic [ALU_OP_WIDTH-1:0] OP_EQ  = 4'b1000;
    localparam logic [ALU_OP_WIDTH-1:0] OP_NOP = 4'b1111;

    typedef enum logic [1:0] {
        ALUOP_MEM    = 2'b00,
        ALUOP_BRANCH = 2'b01,
        ALUOP_RTYPE  = 2'b10,
        ALUOP_ITYPE  = 2'b11
    } alu_op_e;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    typedef struct packed {
        logic [ALU_DATA_WIDTH-1:0] src_a;
        logic [ALU_DATA_WIDTH-1:0] src_b;
        logic [ALU_OP_WIDTH-1:0]   operation;
        logic                      illegal;
    } issue_payload_t;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Decode-to-execute issue bus. master = surrounding pipeline, slave = the issue stage.
interface alu_issue_stage_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
);
    logic                     in_valid;
    logic                     in_ready;
    logic [1:0]               ALUOp;
    logic [2:0]               Funct3;
    logic [6:0]               Funct7;
    logic                     ALUSrc;
    logic [DATA_WIDTH-1:0]    RD1;
    logic [DATA_WIDTH-1:0]    RD2;
    logic [DATA_WIDTH-1:0]    Imm;
    logic                     flush;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_WIDTH-1:0]    SrcA;
    logic [DATA_WIDTH-1:0]    SrcB;
    logic [OPCODE_LENGTH-1:0] Operation;
    logic                     illegal_op;

    modport master (
        output in_valid, ALUOp, Funct3, Funct7, ALUSrc, RD1, RD2, Imm, flush, out_ready,
        input  in_ready, out_valid, SrcA, SrcB, Operation, illegal_op
    );

    modport slave (
        input  in_valid, ALUOp, Funct3, Funct7, ALUSrc, RD1, RD2, Imm, flush, out_ready,
        output in_ready, out_valid, SrcA, SrcB, Operation, illegal_op
    );
endinterface

// File: rtl/alu_op_decode.sv
// Combinational ALUOp/Funct3/Funct7[5] to 4-bit ALU operation decode, with illegal flag.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [1:0]              alu_op_i,
    input  logic [2:0]              funct3_i,
    input  logic                    funct7_b5_i,
    output logic [ALU_OP_WIDTH-1:0] operation_o,
    output logic                    illegal_o
);
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        operation_o = OP_NOP;
        illegal_o   = 1'b0;
        case (alu_op_e'(alu_op_i))
            ALUOP_MEM:    operation_o = OP_ADD;
            ALUOP_BRANCH: operation_o = (funct3_i == F3_BEQ) ? OP_EQ : OP_SUB;
            ALUOP_RTYPE, ALUOP_ITYPE: begin
                case (funct3_i)
                    // Funct7[5] selects SUB only for register-register ops.
                    F3_ADD_SUB: operation_o = (alu_op_e'(alu_op_i) == ALUOP_RTYPE && funct7_b5_i)
                                              ? OP_SUB : OP_ADD;
                    F3_AND:     operation_o = OP_AND;
                    F3_OR:      operation_o = OP_OR;
                    F3_XOR:     operation_o = OP_XOR;
                    default:    illegal_o   = 1'b1;
                endcase
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/alu_issue_stage.sv
// Registered decode-to-execute issue stage with stall/flush handshake.
// Define ALU_ISSUE_SKID_EN to add a one-entry skid buffer and a registered in_ready.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH    = ALU_DATA_WIDTH,
    parameter int OPCODE_LENGTH = ALU_OP_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_issue_stage_if.slave  bus
);
    logic [OPCODE_LENGTH-1:0] dec_op;
    logic                     dec_illegal;
    logic [DATA_WIDTH-1:0]    src_b_sel;
    issue_payload_t           in_pl;
    issue_payload_t           out_q, out_d;
    logic                     out_valid_q, out_valid_d;
    logic                     accept;
    logic                     unused_funct7;

    alu_op_decode u_decode (
        .alu_op_i    (bus.ALUOp),
        .funct3_i    (bus.Funct3),
        .funct7_b5_i (bus.Funct7[5]),
        .operation_o (dec_op),
        .illegal_o   (dec_illegal)
    );

    assign unused_funct7 = ^{bus.Funct7[6], bus.Funct7[4:0]};
    assign src_b_sel     = bus.ALUSrc ? bus.Imm : bus.RD2;
    assign in_pl         = '{src_a: bus.RD1, src_b: src_b_sel, operation: dec_op, illegal: dec_illegal};

`ifdef ALU_ISSUE_SKID_EN
    issue_payload_t skid_q, skid_d;
    logic           skid_valid_q, skid_valid_d;
    logic           out_free;

    assign bus.in_ready = !skid_valid_q;
    assign accept       = bus.in_valid && !skid_valid_q && !bus.flush;
    assign out_free     = !out_valid_q || bus.out_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_d        = out_q;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;
        if (bus.flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_free) begin
            // A parked instruction always drains ahead of new input.
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = accept;
                if (accept) out_d = in_pl;
            end
        end else if (accept) begin
            skid_d       = in_pl;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) skid_valid_q <= 1'b0;
        else        skid_valid_q <= skid_valid_d;
    end

    // NOTE: skid data is only consumed under skid_valid_q, so it needs no reset.
    always_ff @(posedge clk) begin
        skid_q <= skid_d;
    end
`else
    assign bus.in_ready = bus.flush || !out_valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready && !bus.flush;

    always_comb begin
        out_valid_d = out_valid_q;
        out_d       = out_q;
        if (bus.flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            out_d       = in_pl;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.SrcA       = out_q.src_a;
    assign bus.SrcB       = out_q.src_b;
    assign bus.Operation  = out_q.operation;
    assign bus.illegal_op = out_q.illegal;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed cases plus randomized traffic vs a behavioural model.
module tb_alu_issue_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_issue_stage_if #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) bus ();

    alu_issue_stage #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;
    int cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Decode table written straight from the operation-code rules.
    function automatic void spec_decode(input logic [1:0] aop, input logic [2:0] f3,
                                        input logic [6:0] f7, output logic [3:0] op,
                                        output logic ill);
        ill = 1'b0;
        op  = 4'b1111;
        if (aop == 2'b00)      op = 4'b0010;
        else if (aop == 2'b01) op = (f3 == 3'b000) ? 4'b1000 : 4'b0100;
        else begin
            if (f3 == 3'b000)      op = (aop == 2'b10 && f7[5]) ? 4'b0100 : 4'b0010;
            else if (f3 == 3'b111) op = 4'b0000;
            else if (f3 == 3'b110) op = 4'b0001;
            else if (f3 == 3'b100) op = 4'b0011;
            else                   ill = 1'b1;
        end
    endfunction

    // Behavioural model: the stage holds at most one instruction.
    logic        m_valid;
    logic [31:0] m_a, m_b;
    logic [3:0]  m_op;
    logic        m_ill;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 1'b0; m_a = '0; m_b = '0; m_op = '0; m_ill = 1'b0;
        end else begin
            cyc++;
            if (bus.flush) begin
                m_valid = 1'b0;
            end else if (bus.in_valid && (!m_valid || bus.out_ready)) begin
                m_valid = 1'b1;
                m_a     = bus.RD1;
                m_b     = bus.ALUSrc ? bus.Imm : bus.RD2;
                spec_decode(bus.ALUOp, bus.Funct3, bus.Funct7, m_op, m_ill);
            end else if (m_valid && bus.out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    // Per-cycle compare on the falling edge.
    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            check("cyc_out_valid", bus.out_valid, m_valid);
            check("cyc_in_ready", bus.in_ready, bus.flush || !m_valid || bus.out_ready);
            if (m_valid) begin
                check("cyc_SrcA", bus.SrcA, m_a);
                check("cyc_SrcB", bus.SrcB, m_b);
                check("cyc_Operation", bus.Operation, m_op);
                check("cyc_illegal_op", bus.illegal_op, m_ill);
            end
        end
    end

    // Log of consumed outputs for ordering/throughput checks.
    logic [31:0] log_a[$];
    int          log_t[$];
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready && !bus.flush) begin
            log_a.push_back(bus.SrcA);
            log_t.push_back(cyc);
        end
    end

    task automatic set_in(input logic v, input logic [1:0] aop, input logic [2:0] f3,
                          input logic [6:0] f7, input logic src, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] imm, input logic ordy,
                          input logic fl);
        bus.in_valid = v;  bus.ALUOp = aop; bus.Funct3 = f3; bus.Funct7 = f7;
        bus.ALUSrc = src;  bus.RD1 = a;     bus.RD2 = b;     bus.Imm = imm;
        bus.out_ready = ordy; bus.flush = fl;
    endtask

    task automatic drive(input logic v, input logic [1:0] aop, input logic [2:0] f3,
                         input logic [6:0] f7, input logic src, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] imm, input logic ordy,
                         input logic fl);
        set_in(v, aop, f3, f7, src, a, b, imm, ordy, fl);
        @(posedge clk);
        #1;
    endtask

    logic [31:0] exp_seq [5];

    initial begin
        set_in(1'b0, 2'b00, 3'b000, 7'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        #2;
        check("reset_out_valid", bus.out_valid, 1'b0);
        check("reset_Operation", bus.Operation, 4'b0000);
        check("reset_SrcA", bus.SrcA, 32'h0);
        check("reset_SrcB", bus.SrcB, 32'h0);
        check("reset_illegal_op", bus.illegal_op, 1'b0);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;
        cmp_en = 1'b1;

        // R-type SUB
        drive(1'b1, 2'b10, 3'b000, 7'b0100000, 1'b0, 32'd5, 32'd7, 32'h0, 1'b1, 1'b0);
        check("sub_out_valid", bus.out_valid, 1'b1);
        check("sub_Operation", bus.Operation, 4'b0100);
        check("sub_SrcA", bus.SrcA, 32'd5);
        check("sub_SrcB", bus.SrcB, 32'd7);

        // I-type ADD, Funct7 ignored, immediate selected
        drive(1'b1, 2'b11, 3'b000, 7'b0100000, 1'b1, 32'd9, 32'd1, 32'hFFFFFFFC, 1'b1, 1'b0);
        check("iadd_Operation", bus.Operation, 4'b0010);
        check("iadd_SrcB", bus.SrcB, 32'hFFFFFFFC);

        // Branch EQ
        drive(1'b1, 2'b01, 3'b000, 7'b0, 1'b0, 32'd3, 32'd3, 32'h0, 1'b1, 1'b0);
        check("beq_Operation", bus.Operation, 4'b1000);
        check("beq_illegal_op", bus.illegal_op, 1'b0);

        // Illegal R-type funct3
        drive(1'b1, 2'b10, 3'b001, 7'b0, 1'b0, 32'h33, 32'h44, 32'h0, 1'b1, 1'b0);
        check("ill_Operation", bus.Operation, 4'b1111);
        check("ill_illegal_op", bus.illegal_op, 1'b1);
        check("ill_out_valid", bus.out_valid, 1'b1);

        // Stall for 3 cycles with a new instruction waiting
        log_a.delete(); log_t.delete();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'b00, 3'b000, 7'b0, 1'b0, 32'h11, 32'h22, 32'h0, 1'b0, 1'b0);
            check("stall_in_ready", bus.in_ready, 1'b0);
            check("stall_out_valid", bus.out_valid, 1'b1);
            check("stall_Operation", bus.Operation, 4'b1111);
            check("stall_SrcA", bus.SrcA, 32'h33);
            check("stall_SrcB", bus.SrcB, 32'h44);
            check("stall_illegal_op", bus.illegal_op, 1'b1);
        end

        // Stream 4 instructions back to back
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'b00, 3'b000, 7'b0, 1'b0, 32'(100 + i), 32'(i), 32'h0, 1'b1, 1'b0);
            check("stream_out_valid", bus.out_valid, 1'b1);
            check("stream_SrcA", bus.SrcA, 64'(100 + i));
            check("stream_Operation", bus.Operation, 4'b0010);
        end
        drive(1'b0, 2'b00, 3'b000, 7'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        check("drain_out_valid", bus.out_valid, 1'b0);
        exp_seq = '{32'h33, 32'd100, 32'd101, 32'd102, 32'd103};
        check("stream_count", log_a.size(), 5);
        if (log_a.size() == 5) begin
            for (int i = 0; i < 5; i++) begin
                check("stream_order", log_a[i], exp_seq[i]);
                check("stream_consecutive", log_t[i] - log_t[0], i);
            end
        end

        // Flush a stalled instruction together with an incoming one
        log_a.delete(); log_t.delete();
        drive(1'b1, 2'b10, 3'b111, 7'b0, 1'b0, 32'h55, 32'h1, 32'h0, 1'b0, 1'b0);
        check("preflush_out_valid", bus.out_valid, 1'b1);
        check("preflush_Operation", bus.Operation, 4'b0000);
        set_in(1'b1, 2'b00, 3'b000, 7'b0, 1'b0, 32'h66, 32'h0, 32'h0, 1'b0, 1'b1);
        #1;
        check("flush_in_ready", bus.in_ready, 1'b1);
        @(posedge clk);
        #1;
        check("flush_out_valid", bus.out_valid, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 2'b00, 3'b000, 7'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
            check("postflush_out_valid", bus.out_valid, 1'b0);
        end
        check("flush_nothing_emitted", log_a.size(), 0);

        // Asynchronous reset while stalled
        drive(1'b1, 2'b10, 3'b110, 7'b0, 1'b0, 32'h77, 32'h1, 32'h0, 1'b0, 1'b0);
        drive(1'b0, 2'b00, 3'b000, 7'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        check("prerst_out_valid", bus.out_valid, 1'b1);
        check("prerst_Operation", bus.Operation, 4'b0001);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", bus.out_valid, 1'b0);
        check("midrst_Operation", bus.Operation, 4'b0000);
        check("midrst_SrcA", bus.SrcA, 32'h0);
        #4 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("postrst_out_valid", bus.out_valid, 1'b0);

        // Randomized traffic checked by the per-cycle compare
        for (int i = 0; i < 2000; i++) begin
            drive(1'($urandom_range(0, 9) < 7), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                  7'($urandom), 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
                  1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 19) == 0));
        end
        drive(1'b0, 2'b00, 3'b000, 7'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
